divider_control: RTL and testbench
==================================

Name: divider_control

Overview:
- Sequential restoring-divider datapath and controller for 32-bit unsigned division, one quotient bit per cycle.
- Sits directly upstream of the combinational divider ALU.
- Owns the divisor, partial-remainder and quotient/dividend registers.
- Each iteration it drives the ALU subtract operands and consumes the ALU result and borrow.

Parameters:
- WIDTH, 32, operand width. Must equal the ALU width; only 32 is supported.
- ITERS, WIDTH, number of iteration cycles per division.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  32  dividend, captured on accepted start.
- divisor  input  32  divisor, captured on accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  32  quotient, held until the next accepted start.
- remainder  output  32  remainder, held until the next accepted start.
- div_by_zero  output  1  flag for the last division; held with the results.
- alu_src1  output  32  ALU Src1: divisor register.
- alu_src2  output  32  ALU Src2: shifted partial remainder.
- alu_funct  output  6  ALU Funct: 6'b001010 in ITER, 6'b000000 otherwise.
- alu_result  input  32  ALU Result.
- alu_carry  input  1  ALU Carry: 1 means borrow, i.e. Src2 < Src1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers R, Q, D and the iteration counter are cleared.
  - Reset mid-division aborts it with no done pulse.
- States are IDLE, ITER, DONE.
- IDLE:
  - On start=1 with divisor!=0: D<=divisor, Q<=dividend, R<=0, cnt<=0, go to ITER.
  - On start=1 with divisor==0: div_by_zero<=1, go to DONE directly.
  - start=0 keeps IDLE.
- ITER, one cycle per iteration:
  - alu_src2 = {R[30:0], Q[31]} (shifted remainder); alu_src1 = D; alu_funct=6'b001010.
  - alu_carry=0: R<=alu_result; Q<={Q[30:0],1}.
  - alu_carry=1: R<={R[30:0],Q[31]}; Q<={Q[30:0],0}. On borrow the ALU returns Src1, so alu_result is ignored.
  - cnt increments each cycle. After cnt reaches ITERS-1, go to DONE.
  - Invariant: R < 2^31 before each shift (R < partial dividend), so the 32-bit subtract never overflows. No carry-out bit is kept.
- DONE, one cycle:
  - done=1; quotient<=Q, remainder<=R; go to IDLE.
  - For divide-by-zero: quotient<=32'hFFFFFFFF, remainder<=dividend value captured at start.
- busy is high in ITER and DONE, so done and busy overlap by one cycle.
- Latency: start accepted at edge N → done high in cycle N+33, with results valid that cycle. Divide-by-zero: done in cycle N+1.
- start while busy is ignored. Back-to-back is allowed: start asserted in the cycle after done is accepted.
- div_by_zero is cleared on the next accepted nonzero-divisor start.
- Outputs are registered. alu_src1, alu_src2 and alu_funct are combinational from registers only.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), sampled with start.
  - When signed_op=1, magnitudes of dividend and divisor are loaded.
  - An extra FIX state between ITER and DONE applies signs: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Latency becomes N+34.
  - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Divide-by-zero is unchanged: quotient 0xFFFFFFFF, remainder = dividend.
- Undefined: no signed_op port, no FIX state; unsigned only.

Test Plan:
- Reset: rst low mid-ITER (cycle 10 of a division) → all outputs 0 immediately, state IDLE, no done pulse after release.
- Basic: dividend=100, divisor=7, start one cycle → done exactly 33 cycles later; quotient=14, remainder=2, div_by_zero=0.
- Extremes:
  - dividend=0xFFFFFFFF, divisor=1 → quotient 0xFFFFFFFF, remainder 0.
  - dividend=0xFFFFFFFF, divisor=0x80000001 → quotient 1, remainder 0x7FFFFFFE.
- Divide-by-zero: dividend=0x12345678, divisor=0 → done next cycle; quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero=1.
- Busy handling: second start asserted at cycle 5 of a 50/3 division → ignored, result 16 r 2. Then a start the cycle after done with 9/9 → 1 r 0.
- DIV_SIGNED_EN: -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, done at 34 cycles. 7/-2 → quotient 0xFFFFFFFD, remainder 1.

Source files
------------

// File: rtl/divider_control.sv
// Restoring-divider controller: one quotient bit per cycle through an external subtract ALU.
// Optional DIV_SIGNED_EN adds the signed_op port and a FIX state that applies operand signs.
module divider_control #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [5:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
`ifdef DIV_SIGNED_EN
    S_FIX,
`endif
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH-1:0] shift_r, iter_r, iter_q, load_q, load_d;
`ifdef DIV_SIGNED_EN
  logic             negq_q, negq_d, negr_q, negr_d;
`endif

  assign shift_r   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign iter_r    = alu_carry ? shift_r : alu_result;
  assign iter_q    = {q_q[WIDTH-2:0], ~alu_carry};

  assign alu_src1  = d_q;
  assign alu_src2  = shift_r;
  assign alu_funct = (state_q == S_ITER) ? 6'b001010 : 6'b000000;

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // Signed operation divides magnitudes; the most negative value maps to itself as unsigned.
`ifdef DIV_SIGNED_EN
  assign load_q = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign load_d = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
`else
  assign load_q = dividend;
  assign load_d = divisor;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            dbz_d   = 1'b0;
            d_d     = load_d;
            q_d     = load_q;
            r_d     = '0;
            cnt_d   = '0;
            state_d = S_ITER;
`ifdef DIV_SIGNED_EN
            negq_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negr_d  = signed_op & dividend[WIDTH-1];
`endif
          end
        end
      end
      S_ITER: begin
        r_d   = iter_r;
        q_d   = iter_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef DIV_SIGNED_EN
          state_d = S_FIX;
`else
          // Results are registered as the final iteration lands so they are valid while done is high.
          state_d = S_DONE;
          done_d  = 1'b1;
          quot_d  = iter_q;
          rem_d   = iter_r;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      S_FIX: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        quot_d  = negq_q ? -q_q : q_q;
        rem_d   = negr_q ? -r_q : r_q;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

endmodule

// File: tb/tb_divider_control.sv
// Directed bench for divider_control with a behavioural subtract ALU; signed cases need DIV_SIGNED_EN.
module tb_divider_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        signed_op = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder, alu_src1, alu_src2, alu_result;
  logic [5:0]  alu_funct;
  logic        alu_carry;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  always #5 clk = ~clk;

  // ALU: Src2 - Src1, borrow when Src2 < Src1, returns Src1 on borrow.
  assign alu_carry  = alu_src2 < alu_src1;
  assign alu_result = alu_carry ? alu_src1 : alu_src2 - alu_src1;

  divider_control dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_funct(alu_funct), .alu_result(alu_result), .alu_carry(alu_carry)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives start for exactly one accepting edge; cyc counts edges after acceptance.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic waitDone(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dbz, input int exp_lat);
    while (!done && cyc < 100) tick();
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
    checkOutput({tag, "_quotient"}, quotient, exp_q);
    checkOutput({tag, "_remainder"}, remainder, exp_r);
    checkOutput({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
    tick();
    checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_busy_clear"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_q_held"}, quotient, exp_q);
  endtask

  initial begin
    #12;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_quotient", quotient, 32'd0);
    checkOutput("rst_remainder", remainder, 32'd0);
    rst = 1'b1;
    tick();

    applyStimulus(32'd100, 32'd7);
    tick();
    checkOutput("iter_funct", {26'b0, alu_funct}, 32'h0000000A);
    checkOutput("iter_src1", alu_src1, 32'd7);
    waitDone("basic", 32'd14, 32'd2, 1'b0, LAT);

    applyStimulus(32'hFFFFFFFF, 32'd1);
    waitDone("max_div1", 32'hFFFFFFFF, 32'd0, 1'b0, LAT);

    applyStimulus(32'hFFFFFFFF, 32'h80000001);
    waitDone("max_big", 32'd1, 32'h7FFFFFFE, 1'b0, LAT);

    applyStimulus(32'h12345678, 32'd0);
    checkOutput("dbz_funct", {26'b0, alu_funct}, 32'd0);
    waitDone("dbz", 32'hFFFFFFFF, 32'h12345678, 1'b1, 0);

    // Second start during ITER must not restart the division.
    applyStimulus(32'd50, 32'd3);
    repeat (4) tick();
    dividend = 32'd9;
    divisor  = 32'd9;
    start    = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_mid", {31'b0, busy}, 32'd1);
    waitDone("busy_ignore", 32'd16, 32'd2, 1'b0, LAT);

    applyStimulus(32'd9, 32'd9);
    waitDone("back2back", 32'd1, 32'd0, 1'b0, LAT);

`ifdef DIV_SIGNED_EN
    signed_op = 1'b1;
    applyStimulus(32'hFFFFFFF9, 32'd2);
    waitDone("s_neg7_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT);
    applyStimulus(32'd7, 32'hFFFFFFFE);
    waitDone("s_7_neg2", 32'hFFFFFFFD, 32'd1, 1'b0, LAT);
    applyStimulus(32'h80000000, 32'hFFFFFFFF);
    waitDone("s_minint", 32'h80000000, 32'd0, 1'b0, LAT);
    signed_op = 1'b0;
`endif

    // Asynchronous reset in the middle of a division aborts it.
    applyStimulus(32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    checkOutput("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    checkOutput("abort_funct", {26'b0, alu_funct}, 32'd0);
    checkOutput("abort_src1", alu_src1, 32'd0);
    #3;
    rst = 1'b1;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);
    checkOutput("abort_idle_busy", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
